// File: rtl/boa_uart_dbg_bridge.sv
// UART-to-bus debug bridge: framed W/R/P command packets on rxd become single-word bus
// transactions, and the results go back on txd. Optional inter-byte timeout: BOA_UART_BRIDGE_TIMEOUT_EN.

module unbuffered_uart_rx #(
  parameter int clk_div = 1250,
  parameter int dlen    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_trig,
  output logic [7:0] rx_data
);
  localparam int DIV = (clk_div == 0) ? 1 : clk_div;
  localparam logic [dlen-1:0] LAST = dlen'(DIV - 1);
  localparam logic [dlen-1:0] HALF = dlen'((DIV - 1) / 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       state_reg;
  logic [1:0]      sync_reg;
  logic [dlen-1:0] cnt_reg;
  logic [2:0]      bit_reg;
  logic [7:0]      sh_reg;
  logic            rxd_s;

  assign rxd_s = sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RX_IDLE;
      sync_reg  <= 2'b11;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      sh_reg    <= '0;
      rx_trig   <= 1'b0;
      rx_data   <= '0;
    end else begin
      sync_reg <= {sync_reg[0], rxd};
      rx_trig  <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          cnt_reg <= '0;
          if (!rxd_s) state_reg <= RX_START;
        end
        RX_START: begin
          // Re-check the start bit near its centre to reject glitches.
          if (cnt_reg == HALF) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            state_reg <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_reg == LAST) begin
            cnt_reg <= '0;
            sh_reg  <= {rxd_s, sh_reg[7:1]};
            bit_reg <= bit_reg + 1'b1;
            if (bit_reg == 3'd7) state_reg <= RX_STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            state_reg <= RX_IDLE;
            if (rxd_s) begin
              rx_trig <= 1'b1;
              rx_data <= sh_reg;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

module unbuffered_uart_tx #(
  parameter int clk_div = 1250,
  parameter int dlen    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_trig,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       busy
);
  localparam int DIV = (clk_div == 0) ? 1 : clk_div;
  localparam logic [dlen-1:0] LAST = dlen'(DIV - 1);

  logic [dlen-1:0] cnt_reg;
  logic [3:0]      bit_reg;
  logic [8:0]      sh_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      txd     <= 1'b1;
      busy    <= 1'b0;
      cnt_reg <= '0;
      bit_reg <= '0;
      sh_reg  <= '1;
    end else if (!busy) begin
      if (tx_trig) begin
        txd     <= 1'b0;
        sh_reg  <= {1'b1, tx_data};
        busy    <= 1'b1;
        cnt_reg <= '0;
        bit_reg <= '0;
      end
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
      // bit_reg 9 is the stop bit; busy drops at its end.
      if (bit_reg == 4'd9) begin
        busy <= 1'b0;
        txd  <= 1'b1;
      end else begin
        txd     <= sh_reg[0];
        sh_reg  <= {1'b1, sh_reg[8:1]};
        bit_reg <= bit_reg + 1'b1;
      end
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
endmodule

module boa_uart_dbg_bridge #(
  parameter int clk_div = 1250,
  parameter int dlen    = 16,
  parameter int timeout = 1048575
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_wdata,
  output logic        bus_re,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_ARG, S_BUS, S_RESP} state_t;

  state_t      state_reg;
  logic [63:0] arg_sr_reg;
  logic [2:0]  arg_cnt_reg;
  logic        is_write_reg;
  logic [23:0] resp_sr_reg;
  logic [1:0]  resp_cnt_reg;
  logic        tx_trig_reg;
  logic [7:0]  tx_data_reg;
  logic        tx_ack_q_reg;
  logic        busy_reg;
  logic [29:0] addr_reg;
  logic [3:0]  we_reg;
  logic [31:0] wdata_reg;
  logic        re_reg;

  logic        rx_trig;
  logic [7:0]  rx_data;
  logic        tx_ack;
  logic [63:0] arg_next;

  unbuffered_uart_rx #(.clk_div(clk_div), .dlen(dlen)) u_rx (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_trig(rx_trig), .rx_data(rx_data)
  );

  unbuffered_uart_tx #(.clk_div(clk_div), .dlen(dlen)) u_tx (
    .clk(clk), .rst(rst), .tx_trig(tx_trig_reg), .tx_data(tx_data_reg),
    .txd(txd), .busy(tx_ack)
  );

  // Arguments shift in from the top, so after the final byte the packet sits little-endian.
  assign arg_next = {rx_data, arg_sr_reg[63:8]};

`ifdef BOA_UART_BRIDGE_TIMEOUT_EN
  localparam logic [19:0] TO_LIMIT = 20'(timeout);
  logic [19:0] to_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) to_cnt_reg <= '0;
    else     to_cnt_reg <= (state_reg == S_ARG && !rx_trig) ? to_cnt_reg + 1'b1 : '0;
  end
`else
  logic [19:0] unused_timeout;
  assign unused_timeout = 20'(timeout);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      arg_sr_reg   <= '0;
      arg_cnt_reg  <= '0;
      is_write_reg <= 1'b0;
      resp_sr_reg  <= '0;
      resp_cnt_reg <= '0;
      tx_trig_reg  <= 1'b0;
      tx_data_reg  <= '0;
      tx_ack_q_reg <= 1'b0;
      busy_reg     <= 1'b0;
      addr_reg     <= '0;
      we_reg       <= '0;
      wdata_reg    <= '0;
      re_reg       <= 1'b0;
    end else begin
      tx_trig_reg  <= 1'b0;
      tx_ack_q_reg <= tx_ack;
      busy_reg     <= (state_reg != S_IDLE);
      case (state_reg)
        S_IDLE: begin
          if (rx_trig) begin
            arg_cnt_reg <= '0;
            case (rx_data)
              8'h57: begin is_write_reg <= 1'b1; state_reg <= S_ARG; end
              8'h52: begin is_write_reg <= 1'b0; state_reg <= S_ARG; end
              default: begin
                tx_data_reg  <= (rx_data == 8'h50) ? 8'hA5 : 8'h15;
                tx_trig_reg  <= 1'b1;
                resp_cnt_reg <= '0;
                state_reg    <= S_RESP;
              end
            endcase
          end
        end
        S_ARG: begin
          if (rx_trig) begin
            arg_sr_reg <= arg_next;
            if (arg_cnt_reg == (is_write_reg ? 3'd7 : 3'd3)) begin
              state_reg <= S_BUS;
              if (is_write_reg) begin
                addr_reg  <= arg_next[31:2];
                wdata_reg <= arg_next[63:32];
                we_reg    <= 4'b1111;
              end else begin
                addr_reg <= arg_next[63:34];
                re_reg   <= 1'b1;
              end
            end else begin
              arg_cnt_reg <= arg_cnt_reg + 1'b1;
            end
          end
`ifdef BOA_UART_BRIDGE_TIMEOUT_EN
          else if (to_cnt_reg == TO_LIMIT) state_reg <= S_IDLE;
`endif
        end
        S_BUS: begin
          if (bus_ready) begin
            re_reg      <= 1'b0;
            we_reg      <= '0;
            tx_trig_reg <= 1'b1;
            state_reg   <= S_RESP;
            if (is_write_reg) begin
              tx_data_reg  <= 8'h06;
              resp_cnt_reg <= '0;
            end else begin
              tx_data_reg  <= bus_rdata[7:0];
              resp_sr_reg  <= bus_rdata[31:8];
              resp_cnt_reg <= 2'd3;
            end
          end
        end
        default: begin
          // Falling TX busy marks the end of a stop bit: chain the next reply byte or finish.
          if (tx_ack_q_reg && !tx_ack) begin
            if (resp_cnt_reg == 2'd0) begin
              state_reg <= S_IDLE;
            end else begin
              tx_data_reg  <= resp_sr_reg[7:0];
              resp_sr_reg  <= {8'h00, resp_sr_reg[23:8]};
              resp_cnt_reg <= resp_cnt_reg - 1'b1;
              tx_trig_reg  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus_addr  = addr_reg;
  assign bus_we    = we_reg;
  assign bus_wdata = wdata_reg;
  assign bus_re    = re_reg;
  assign busy      = busy_reg;
endmodule
